// File: rtl/fpu_pkg.sv
// fpu_pkg: shared floating-point types and helpers for the FPU datapath.
// Holds the operand class enum, the special-result selector, flag bit
// indices, the exponent bias function and the canonical quiet-NaN builder.
package fpu_pkg;

    typedef enum logic [2:0] {
        ZERO,
        NORMAL,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF,
        SPC_ZERO
    } fp_special_e;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_W         = 4;

    // Exponent bias for an exponent field of expW bits
    function automatic int fp_bias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned;
    // callers cast it down to their operand width
    function automatic logic [63:0] fp_canon_nan(input int expW, input int manW);
        logic [63:0] v;
        v = ((64'd1 << expW) - 64'd1) << manW;
        v = v | (64'd1 << (manW - 1));
        return v;
    endfunction

    // Classify an operand from its field summaries; subnormals count as ZERO
    function automatic fp_class_e fp_classify(input logic expOnes, input logic expZero,
                                              input logic fracZero, input logic fracMsb);
        fp_class_e c;
        if (expZero)
            c = ZERO;
        else if (!expOnes)
            c = NORMAL;
        else if (fracZero)
            c = INF;
        else if (fracMsb)
            c = QNAN;
        else
            c = SNAN;
        return c;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational normalise, round-to-nearest-even, overflow to
// infinity, flush-to-zero and pack. Optional IEEE flags when FMUL_FLAGS_EN
// is defined.
module fp_round_pack
    import fpu_pkg::*;
#(
    parameter  int EXP_W  = 8,
    parameter  int MAN_W  = 23,
    localparam int FP_W   = 1 + EXP_W + MAN_W,
    localparam int PROD_W = 2 * (MAN_W + 1),
    localparam int SEXP_W = EXP_W + 2
)
(
    input  logic              i_sign,
    input  logic [SEXP_W-1:0] i_exp,
    input  logic [PROD_W-1:0] i_prod,
    input  fp_special_e       i_special,
    output logic [FP_W-1:0]   o_result
`ifdef FMUL_FLAGS_EN
    ,
    input  logic              i_invalid,
    output logic [FLAG_W-1:0] o_flags
`endif
);

    localparam int                EXP_MAX   = (1 << EXP_W) - 1;
    localparam logic [SEXP_W-1:0] SEXP_ONE  = SEXP_W'(1);
    localparam logic [FP_W-1:0]   CANON_NAN = FP_W'(fp_canon_nan(EXP_W, MAN_W));

    logic [PROD_W-1:0]  w_norm;
    logic [SEXP_W-1:0]  w_expNorm;
    logic [SEXP_W-1:0]  w_expRound;
    logic [MAN_W:0]     w_mant;
    logic [MAN_W+1:0]   w_mantRound;
    logic [MAN_W-1:0]   w_frac;
    logic               w_guard;
    logic               w_sticky;
    logic               w_roundUp;
    logic               w_ovf;
    logic               w_unf;

    // Normalise the product, round to nearest even, range-check and pack
    always_comb begin
        w_norm    = i_prod[PROD_W-1] ? i_prod : (i_prod << 1);
        w_expNorm = i_prod[PROD_W-1] ? (i_exp + SEXP_ONE) : i_exp;

        w_mant    = w_norm[PROD_W-1 -: MAN_W+1];
        w_guard   = w_norm[MAN_W];
        w_sticky  = |w_norm[MAN_W-1:0];
        w_roundUp = w_guard && (w_sticky || w_mant[0]);

        w_mantRound = {1'b0, w_mant} + (MAN_W+2)'(w_roundUp);
        if (w_mantRound[MAN_W+1]) begin
            w_frac     = '0;
            w_expRound = w_expNorm + SEXP_ONE;
        end else begin
            w_frac     = w_mantRound[MAN_W-1:0];
            w_expRound = w_expNorm;
        end

        w_ovf = !w_expRound[SEXP_W-1] &&
                (w_expRound[SEXP_W-2:0] >= (SEXP_W-1)'(EXP_MAX));
        w_unf = w_expRound[SEXP_W-1] || (w_expRound == '0);

        if (w_ovf)
            o_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_unf)
            o_result = {i_sign, {(FP_W-1){1'b0}}};
        else
            o_result = {i_sign, w_expRound[EXP_W-1:0], w_frac};

        case (i_special)
            SPC_NAN:  o_result = CANON_NAN;
            SPC_INF:  o_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SPC_ZERO: o_result = {i_sign, {(FP_W-1){1'b0}}};
            default:  ;
        endcase
    end

`ifdef FMUL_FLAGS_EN
    // Exception flags; range and rounding flags only apply to finite products
    always_comb begin
        o_flags = '0;
        if (i_special == SPC_NONE) begin
            o_flags[FLAG_OVERFLOW]  = w_ovf;
            o_flags[FLAG_UNDERFLOW] = w_unf;
            o_flags[FLAG_INEXACT]   = w_guard || w_sticky || w_ovf || w_unf;
        end
        o_flags[FLAG_INVALID] = i_invalid;
    end
`endif

endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage pipelined floating-point multiplier with a global
// valid/ready stall. S1 decodes and classifies, S2 multiplies mantissas,
// S3 rounds and packs through fp_round_pack. Optional flags output is
// enabled with the FMUL_FLAGS_EN macro.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int FP_W  = 1 + EXP_W + MAN_W
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out
`ifdef FMUL_FLAGS_EN
    ,
    output logic [FLAG_W-1:0] flags
`endif
);

    localparam int                SEXP_W = EXP_W + 2;
    localparam int                PROD_W = 2 * (MAN_W + 1);
    localparam logic [SEXP_W-1:0] BIAS   = SEXP_W'(fp_bias(EXP_W));

    logic               w_adv;
    logic [EXP_W-1:0]   w_expA;
    logic [EXP_W-1:0]   w_expB;
    logic [MAN_W-1:0]   w_fracA;
    logic [MAN_W-1:0]   w_fracB;
    fp_class_e          w_clsA;
    fp_class_e          w_clsB;
    fp_special_e        w_special;
    logic [SEXP_W-1:0]  w_expSum;
    logic [FP_W-1:0]    w_result;

    logic               r_s1Valid;
    logic               r_s1Sign;
    logic [SEXP_W-1:0]  r_s1Exp;
    logic [MAN_W:0]     r_s1MantA;
    logic [MAN_W:0]     r_s1MantB;
    fp_special_e        r_s1Special;

    logic               r_s2Valid;
    logic               r_s2Sign;
    logic [SEXP_W-1:0]  r_s2Exp;
    logic [PROD_W-1:0]  r_s2Prod;
    fp_special_e        r_s2Special;

    logic               r_s3Valid;
    logic [FP_W-1:0]    r_out;

`ifdef FMUL_FLAGS_EN
    logic               w_invalid;
    logic               r_s1Invalid;
    logic               r_s2Invalid;
    logic [FLAG_W-1:0]  w_flags;
    logic [FLAG_W-1:0]  r_flags;
`endif

    assign w_adv     = !r_s3Valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_s3Valid;
    assign out       = r_out;

    // Decode both operands and resolve special-case priority for S1
    always_comb begin
        w_expA  = a[FP_W-2 -: EXP_W];
        w_expB  = b[FP_W-2 -: EXP_W];
        w_fracA = a[MAN_W-1:0];
        w_fracB = b[MAN_W-1:0];
        w_clsA  = fp_classify(&w_expA, ~|w_expA, ~|w_fracA, w_fracA[MAN_W-1]);
        w_clsB  = fp_classify(&w_expB, ~|w_expB, ~|w_fracB, w_fracB[MAN_W-1]);

        w_special = SPC_NONE;
        if (w_clsA == QNAN || w_clsA == SNAN || w_clsB == QNAN || w_clsB == SNAN)
            w_special = SPC_NAN;
        else if ((w_clsA == INF && w_clsB == ZERO) || (w_clsA == ZERO && w_clsB == INF))
            w_special = SPC_NAN;
        else if (w_clsA == INF || w_clsB == INF)
            w_special = SPC_INF;
        else if (w_clsA == ZERO || w_clsB == ZERO)
            w_special = SPC_ZERO;

        w_expSum = SEXP_W'(w_expA) + SEXP_W'(w_expB) - BIAS;
    end

`ifdef FMUL_FLAGS_EN
    // Invalid covers signalling NaN inputs and the inf*0 product
    always_comb begin
        w_invalid = (w_clsA == SNAN) || (w_clsB == SNAN) ||
                    (w_clsA == INF && w_clsB == ZERO) ||
                    (w_clsA == ZERO && w_clsB == INF);
    end
`endif

    // Stage valid bits shift together whenever the output can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s3Valid <= 1'b0;
        end else if (w_adv) begin
            r_s1Valid <= in_valid;
            r_s2Valid <= r_s1Valid;
            r_s3Valid <= r_s2Valid;
        end
    end

    // S1 capture of decoded operands
    always_ff @(posedge clk) begin
        if (w_adv && in_valid) begin
            r_s1Sign    <= a[FP_W-1] ^ b[FP_W-1];
            r_s1Exp     <= w_expSum;
            r_s1MantA   <= {1'b1, w_fracA};
            r_s1MantB   <= {1'b1, w_fracB};
            r_s1Special <= w_special;
`ifdef FMUL_FLAGS_EN
            r_s1Invalid <= w_invalid;
`endif
        end
    end

    // S2 full-width mantissa product
    always_ff @(posedge clk) begin
        if (w_adv && r_s1Valid) begin
            r_s2Sign    <= r_s1Sign;
            r_s2Exp     <= r_s1Exp;
            r_s2Prod    <= PROD_W'(r_s1MantA) * PROD_W'(r_s1MantB);
            r_s2Special <= r_s1Special;
`ifdef FMUL_FLAGS_EN
            r_s2Invalid <= r_s1Invalid;
`endif
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_roundPack (
        .i_sign    (r_s2Sign),
        .i_exp     (r_s2Exp),
        .i_prod    (r_s2Prod),
        .i_special (r_s2Special),
        .o_result  (w_result)
`ifdef FMUL_FLAGS_EN
        ,
        .i_invalid (r_s2Invalid),
        .o_flags   (w_flags)
`endif
    );

    // S3 result register; cleared by reset and held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_adv && r_s2Valid) begin
            r_out <= w_result;
        end
    end

`ifdef FMUL_FLAGS_EN
    // Flags travel with the result they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_adv && r_s2Valid) begin
            r_flags <= w_flags;
        end
    end

    assign flags = r_flags;
`endif

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: self-checking bench for fmul_pipe at fp32 defaults.
// Directed vectors, latency, backpressure, mid-flight reset and a random
// phase scored against an arithmetic reference model.
module tb_fmul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
`ifdef FMUL_FLAGS_EN
    logic [3:0]  flags;
`endif

    int errCount   = 0;
    int checkCount = 0;
    int outCount   = 0;

    logic [35:0] expQ[$];
    logic        prevStall = 1'b0;
    logic [31:0] prevOut   = '0;

    fmul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef FMUL_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every comparison and report any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference product from real-number reasoning: exact integer product,
    // keep 24 significant bits, round half to even by remainder comparison.
    // Returns {invalid, overflow, underflow, inexact, result}.
    function automatic logic [35:0] refMul(input logic [31:0] x, input logic [31:0] y);
        int              ex, ey, e, sh;
        logic            s;
        longint unsigned mx, my, p, q, rem, half;
        logic            nanX, nanY, snanX, snanY, infX, infY, zeroX, zeroY, inexact;
        s     = x[31] ^ y[31];
        ex    = int'(x[30:23]);
        ey    = int'(y[30:23]);
        nanX  = (ex == 255) && (x[22:0] != 0);
        nanY  = (ey == 255) && (y[22:0] != 0);
        snanX = nanX && !x[22];
        snanY = nanY && !y[22];
        infX  = (ex == 255) && (x[22:0] == 0);
        infY  = (ey == 255) && (y[22:0] == 0);
        zeroX = (ex == 0);
        zeroY = (ey == 0);
        if (nanX || nanY)
            return {snanX || snanY, 3'b000, 32'h7FC00000};
        if ((infX && zeroY) || (zeroX && infY))
            return {4'b1000, 32'h7FC00000};
        if (infX || infY)
            return {4'b0000, s, 8'hFF, 23'h0};
        if (zeroX || zeroY)
            return {4'b0000, s, 31'h0};
        mx = 64'(x[22:0]) + 64'h800000;
        my = 64'(y[22:0]) + 64'h800000;
        p  = mx * my;
        sh = (p >= 64'h8000_0000_0000) ? 24 : 23;
        e  = ex + ey - 127 + (sh - 23);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inexact = (rem != 0);
        if (rem > half || (rem == half && q[0]))
            q = q + 1;
        if (q == 64'h100_0000) begin
            q = 64'h80_0000;
            e = e + 1;
        end
        if (e >= 255)
            return {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0)
            return {4'b0011, s, 31'h0};
        return {3'b000, inexact, s, 8'(e), q[22:0]};
    endfunction

    // Random operand biased toward specials, subnormals and all-ones mantissas
    function automatic logic [31:0] randOperand();
        logic [31:0] v;
        int          k;
        k = int'($urandom_range(0, 19));
        v = $urandom;
        case (k)
            0:       v[30:0]  = '0;
            1:       v[30:0]  = {8'hFF, 23'h0};
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4: begin
                     v[30:23] = 8'($urandom_range(1, 254));
                     v[22:0]  = '1;
            end
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    // Present one operand pair and hold it until the pipe takes it
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
        int waitCycles;
        waitCycles = 0;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready)
            checkOutput("inReadyTimeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send one pair into an empty pipe and compare against a known product
    task automatic runDirected(input string tag, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] expv, input logic [3:0] expFlags);
        int n;
        n = 0;
        applyStimulus(x, y);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "Valid"}, 64'(out_valid), 64'd1);
        checkOutput(tag, 64'(out), 64'(expv));
`ifdef FMUL_FLAGS_EN
        checkOutput({tag, "Flags"}, 64'(flags), 64'(expFlags));
`else
        if (expFlags === 4'bxxxx)
            $display("[TB] flags not built");
`endif
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted operands, score each delivered result and
    // confirm the output holds while the consumer stalls
    always @(negedge clk) begin
        logic [35:0] expv;
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (in_valid && in_ready)
                expQ.push_back(refMul(a, b));
            if (prevStall && out_valid)
                checkOutput("stallHold", 64'(out), 64'(prevOut));
            if (out_valid && out_ready) begin
                outCount++;
                if (expQ.size() == 0) begin
                    checkOutput("spurious", 64'd1, 64'd0);
                end else begin
                    expv = expQ.pop_front();
                    checkOutput("model", 64'(out), 64'(expv[31:0]));
`ifdef FMUL_FLAGS_EN
                    checkOutput("modelFlags", 64'(flags), 64'(expv[35:32]));
`endif
                end
            end
            prevStall = out_valid && !out_ready;
            prevOut   = out;
        end
    end

    // Hard stop if something wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          startCount;
        int          n;
        logic [31:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstOut",      64'(out),       64'd0);
        checkOutput("rstInReady",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] latency");
        a = 32'h3FC00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("lat1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("lat2", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("lat3", 64'(out_valid), 64'd1);
        checkOutput("latData", 64'(out), 64'h40400000);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        runDirected("mul3",    32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        runDirected("rndMax",  32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);
        runDirected("ovf",     32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
        runDirected("unf",     32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        runDirected("infZero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        runDirected("negInf",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        runDirected("negZero", 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        runDirected("sNan",    32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        runDirected("qNan",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
        runDirected("daz",     32'h00400000, 32'hC0000000, 32'h80000000, 4'b0000);

        $display("[TB] backpressure");
        out_ready  = 1'b0;
        startCount = outCount;
        applyStimulus(32'h3F800000, 32'h40000000);
        applyStimulus(32'h40000000, 32'h40000000);
        applyStimulus(32'h40400000, 32'h40000000);
        a        = 32'h40800000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        held     = out;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("bpInReady", 64'(in_ready),  64'd0);
            checkOutput("bpValid",   64'(out_valid), 64'd1);
            checkOutput("bpHold",    64'(out),       64'(held));
        end
        checkOutput("bpHeadData", 64'(held), 64'h40000000);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(32'h40800000, 32'h40000000);
        applyStimulus(32'h40A00000, 32'h40000000);
        n = 0;
        while (outCount - startCount < 5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bpCount", 64'(outCount - startCount), 64'd5);
        @(posedge clk);
        #1;

        $display("[TB] reset with ops in flight");
        applyStimulus(32'h3F800000, 32'h3F800000);
        applyStimulus(32'h40000000, 32'h3F800000);
        applyStimulus(32'h40400000, 32'h3F800000);
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midRstValid", 64'(out_valid), 64'd0);
        checkOutput("midRstOut",   64'(out),       64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("rstNoOut", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = randOperand();
            b         = randOperand();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput("drain", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
